// File: rtl/fp_accum_seq_pkg.sv
// Shared fp definitions for the accumulation stage: default field widths,
// sFlags / exception / rounding bit indices and the sequencer state encoding.
package fp_accum_seq_pkg;

    localparam int FP_NEXP        = 5;
    localparam int FP_NSIG        = 10;
    localparam int FP_NTYPES      = 6;
    localparam int FP_NEXCEPTIONS = 5;
    localparam int FP_NRAS        = 4;
    localparam int FP_CNTW        = 16;

    // sFlags bit indices
    localparam int FLAG_NORMAL    = 0;
    localparam int FLAG_SUBNORMAL = 1;
    localparam int FLAG_ZERO      = 2;
    localparam int FLAG_INFINITY  = 3;
    localparam int FLAG_QNAN      = 4;
    localparam int FLAG_SNAN      = 5;

    // exception bit indices
    localparam int EXC_INVALID      = 0;
    localparam int EXC_DIVIDEBYZERO = 1;
    localparam int EXC_OVERFLOW     = 2;
    localparam int EXC_UNDERFLOW    = 3;
    localparam int EXC_INEXACT      = 4;

    // rounding attribute one-hot indices
    localparam int RA_TIES_EVEN  = 0;
    localparam int RA_TOWARD_ZERO = 1;
    localparam int RA_TOWARD_NEG = 2;
    localparam int RA_TOWARD_POS = 3;
    localparam int RA_TIES_AWAY  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } acc_state_e;

endpackage

// File: rtl/fp_accum_seq.sv
// fp_accum_seq: sequential accumulator placed in front of the combinational
// fp_as adder. It feeds {running sum, element} to fp_as, registers the sum on
// every accepted beat and presents one result per vector (ended by in_last).
// Optional build macro FP_ACCUM_COUNT_EN adds the out_count element counter.
module fp_accum_seq
    import fp_accum_seq_pkg::*;
#(
    parameter int NEXP        = FP_NEXP,
    parameter int NSIG        = FP_NSIG,
    parameter int NTYPES      = FP_NTYPES,
    parameter int NEXCEPTIONS = FP_NEXCEPTIONS,
    parameter int NRAS        = FP_NRAS
`ifdef FP_ACCUM_COUNT_EN
    ,
    parameter int CNTW        = FP_CNTW
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NEXP+NSIG:0]     in_data,
    input  logic                   in_sub,
    input  logic [NRAS:0]          in_ra,
    input  logic                   in_last,
    output logic [NEXP+NSIG:0]     as_a,
    output logic [NEXP+NSIG:0]     as_b,
    output logic                   as_subtract,
    output logic [NRAS:0]          as_ra,
    input  logic [NEXP+NSIG:0]     as_s,
    input  logic [NTYPES-1:0]      as_sflags,
    input  logic [NEXCEPTIONS-1:0] as_exception,
    output logic                   out_valid,
    input  logic                   out_ready,
`ifdef FP_ACCUM_COUNT_EN
    output logic [CNTW-1:0]        out_count,
`endif
    output logic [NEXP+NSIG:0]     out_sum,
    output logic [NTYPES-1:0]      out_sflags,
    output logic [NEXCEPTIONS-1:0] out_exception
);

    acc_state_e               state_q, state_d;
    logic [NEXP+NSIG:0]       acc_q, acc_d;
    logic [NRAS:0]            ra_q, ra_d;
    logic [NTYPES-1:0]        sflags_q, sflags_d;
    logic [NEXCEPTIONS-1:0]   exc_q, exc_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic                     hs_s;

`ifdef FP_ACCUM_COUNT_EN
    logic [CNTW-1:0]          cnt_q, cnt_d;
`endif

    // The adder always sees the running sum and the element on the bus; the
    // rounding attribute is live from the input only before a vector starts.
    assign as_a        = acc_q;
    assign as_b        = in_data;
    assign as_subtract = in_sub;
    assign as_ra       = (state_q == ST_IDLE) ? in_ra : ra_q;

    assign hs_s = in_valid & in_ready_q;

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_sum       = acc_q;
    assign out_sflags    = sflags_q;
    assign out_exception = exc_q;
`ifdef FP_ACCUM_COUNT_EN
    assign out_count     = cnt_q;
`endif

    // Next-state and datapath update for the IDLE/ACCUM/DONE sequencer.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        ra_d     = ra_q;
        sflags_d = sflags_q;
        exc_d    = exc_q;
`ifdef FP_ACCUM_COUNT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (hs_s) begin
                    acc_d    = as_s;
                    sflags_d = as_sflags;
                    exc_d    = as_exception;
                    ra_d     = in_ra;
                    state_d  = in_last ? ST_DONE : ST_ACCUM;
`ifdef FP_ACCUM_COUNT_EN
                    cnt_d    = {{(CNTW-1){1'b0}}, 1'b1};
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (hs_s) begin
                    acc_d    = as_s;
                    sflags_d = as_sflags;
                    exc_d    = exc_q | as_exception;
                    state_d  = in_last ? ST_DONE : ST_ACCUM;
`ifdef FP_ACCUM_COUNT_EN
                    if (cnt_q != {CNTW{1'b1}}) begin
                        cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_d = cnt_q;
                    end
`endif
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d  = ST_IDLE;
                    acc_d    = '0;
                    sflags_d = '0;
                    exc_d    = '0;
`ifdef FP_ACCUM_COUNT_EN
                    cnt_d    = '0;
`endif
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                acc_d    = '0;
                sflags_d = '0;
                exc_d    = '0;
            end
        endcase

        // Handshake flags are registered copies of where the FSM is headed,
        // giving exactly one dead cycle (DONE) between vectors.
        in_ready_d  = (state_d != ST_DONE);
        out_valid_d = (state_d == ST_DONE);
    end

    // State register with synchronous reset; reset abandons any partial vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            ra_q        <= '0;
            sflags_q    <= '0;
            exc_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ra_q        <= ra_d;
            sflags_q    <= sflags_d;
            exc_q       <= exc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef FP_ACCUM_COUNT_EN
    // Element counter, loaded on the first beat and saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: doc/fp_accum_seq.md
Name: fp_accum_seq

Overview:
- Sequential accumulation stage that sits directly upstream of the combinational adder/subtractor `fp_as` in the FPU add/sub path.
- Accepts a valid/ready stream of IEEE-754 operands grouped into vectors (end marked by `in_last`).
- Drives `fp_as` with {running sum, incoming element}, registers its result every accepted beat, and presents one sum per vector.
- Output carries sticky exceptions and the final type flags.

Parameters:
- NEXP, 5, exponent field width.
- NSIG, 10, stored significand width; word is NEXP+NSIG+1 bits.
- NTYPES, 6, width of the `fp_as` sFlags type vector.
- NEXCEPTIONS, 5, width of the `fp_as` exception vector.
- NRAS, 4, rounding-attribute MSB index; `ra` is NRAS+1 bits, one-hot.
- CNTW, 16, element counter width (used only with the optional feature).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  element valid.
- in_ready  out  1  element accepted when in_valid & in_ready.
- in_data  in  NEXP+NSIG+1  element.
- in_sub  in  1  1 = subtract this element from the running sum.
- in_ra  in  NRAS+1  rounding attribute; sampled on the first beat of a vector only.
- in_last  in  1  final element of the vector.
- as_a  out  NEXP+NSIG+1  to `fp_as` a (running sum).
- as_b  out  NEXP+NSIG+1  to `fp_as` b (= in_data).
- as_subtract  out  1  to `fp_as` subtract? (= in_sub).
- as_ra  out  NRAS+1  to `fp_as` ra.
- as_s  in  NEXP+NSIG+1  from `fp_as` s.
- as_sflags  in  NTYPES  from `fp_as` sFlags.
- as_exception  in  NEXCEPTIONS  from `fp_as` exception.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_sum  out  NEXP+NSIG+1  accumulated result.
- out_sflags  out  NTYPES  sFlags of the final beat.
- out_exception  out  NEXCEPTIONS  OR of exceptions over all beats of the vector.

Behaviour:
- Reset values: state=IDLE, acc=+0 (all zeros), ra_q=0, sflags_q=0, exc_q=0, out_valid=0; in_ready becomes 1 in the cycle after reset deasserts.
- Reset asserted mid-vector or in DONE abandons the vector; no partial result is ever output.
- Combinational drive in all states:
  - as_a = acc; as_b = in_data; as_subtract = in_sub.
  - as_ra = in_ra in IDLE, else ra_q.
- IDLE state:
  - in_ready = 1.
  - On a handshake: acc <= as_s, sflags_q <= as_sflags, exc_q <= as_exception, ra_q <= in_ra.
  - Next state is DONE if in_last, else ACCUM.
- ACCUM state:
  - in_ready = 1.
  - On a handshake: acc <= as_s, sflags_q <= as_sflags, exc_q <= exc_q | as_exception.
  - in_last moves to DONE; no handshake holds all state.
- DONE state:
  - in_ready = 0, out_valid = 1; out_sum = acc, out_sflags = sflags_q, out_exception = exc_q.
  - Outputs hold stable while out_ready = 0.
  - On out_ready: state returns to IDLE and acc, exc_q, sflags_q clear to 0 in the same edge.
- Timing:
  - Throughput is one element per cycle.
  - out_valid rises the cycle after the in_last handshake.
  - There is exactly one dead cycle (in_ready = 0) between vectors.
- The first element is summed against +0, so a single-element vector returns in_data, or in_data with its sign inverted if in_sub = 1.
- NaN and infinity propagation and rounding are entirely `fp_as` behaviour; this block never alters as_s.
- A non-one-hot in_ra is passed through unchecked.

Optional Feature:
- Macro: FP_ACCUM_COUNT_EN.
- Defined:
  - Adds output port out_count [CNTW-1:0], the number of elements in the vector.
  - Counter loads 1 on the IDLE handshake and increments on each ACCUM handshake, saturating at 2^CNTW-1.
  - Valid while out_valid = 1; resets to 0.
- Undefined: no port, no counter logic.

Decomposition:
- The shared fp package holds:
  - defaults for NEXP, NSIG, NTYPES, NEXCEPTIONS, NRAS;
  - sFlags bit indices (NORMAL, SUBNORMAL, ZERO, INFINITY, QNAN, SNAN);
  - exception indices (INVALID, DIVIDEBYZERO, OVERFLOW, UNDERFLOW, INEXACT);
  - rounding indices;
  - the 2-bit state encoding IDLE=0, ACCUM=1, DONE=2.
- No sub-module. `fp_as` is instantiated alongside by the parent so that a pipelined adder can replace it later.

Test Plan (binary16, `fp_as` connected, ra = roundTiesToEven unless stated):
- Elements {0x3C00, 0x4000(last)}, sub = 0 -> out_sum 0x4200, out_exception 0, out_sflags NORMAL, out_valid 2 cycles after the first beat.
- Elements {0x4200, 0x3C00 sub = 1 (last)} -> out_sum 0x4000.
- Elements {0x7BFF, 0x7BFF(last)} -> out_sum 0x7C00, sflags INFINITY, out_exception OVERFLOW|INEXACT.
- Elements {0x7C00, 0xFC00, 0x3C00(last)} -> out_sum is a qNaN, INVALID held sticky through the third beat.
- Hold out_ready = 0 for 3 cycles after out_valid -> out_sum/flags stable, in_ready = 0; the next vector is accepted one cycle after the out handshake.
- Assert reset after the 2nd of 4 elements, then send {0x3C00(last)} -> out_sum 0x3C00, exceptions 0; with FP_ACCUM_COUNT_EN, out_count = 1.
